mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported 32-bit memory between the CPU instruction-fetch side and the load/store side. Grants one side at a time and runs a req/ack handshake to memory. Converts the CPU's 2-bit memsize plus byte address into word-aligned address, byte strobes and lane-replicated write data, and right-justifies read data. A wait-timeout watchdog aborts accesses that memory never acknowledges.

Parameters:
TIMEOUT, 255, max cycles o_mreq may stay high without i_mack before abort; 0 disables the watchdog.
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, synchronous, active-high
i_ireq  in  1  fetch request; held high until o_iack
i_iaddr  in  32  fetch byte address
o_iack  out  1  one-cycle pulse; o_idata valid this cycle
o_idata  out  32  fetched word
i_dreq  in  1  data request; held high until o_dack
i_dwrite  in  1  1 = store, 0 = load
i_dsize  in  2  00 none, 01 byte, 10 half, 11 word
i_daddr  in  32  data byte address
i_dwdata  in  32  store data, right-justified
o_dack  out  1  one-cycle pulse; o_drdata/o_derr valid this cycle
o_drdata  out  32  load data, right-justified, upper bits zero
o_derr  out  1  access aborted (timeout or misaligned)
o_mreq  out  1  memory request
o_mwe  out  1  memory write enable
o_mstrb  out  4  byte strobes, bit n = byte lane n
o_maddr  out  32  word address, bits [1:0] = 0
o_mwdata  out  32  lane-replicated write data
i_mack  in  1  memory done; i_mrdata valid this cycle
i_mrdata  in  32  memory read word

Behaviour:
- Reset, synchronous, i_rst high at edge: state IDLE; all outputs 0; watchdog 0. Reset mid-access drops o_mreq at that edge. Later i_mack is ignored.
- States: IDLE, IBUSY, DBUSY.
- IDLE: if i_dreq (and not masked), latch d-request fields and go to DBUSY. Else if i_ireq (and not masked), latch i_iaddr and go to IBUSY. When both request, data wins.
- Mask: in the cycle a side's ack is high, that side's req is ignored. Requesters drop req the cycle after seeing ack.
- i_dsize = 00: no memory access. Stay IDLE; o_dack pulses next cycle with o_drdata = 0 and o_derr = 0.
- BUSY: o_mreq, o_maddr, o_mwe, o_mstrb and o_mwdata are registered and held constant from the cycle after the grant until i_mack is sampled high.
- On i_mack: capture read data, go to IDLE, drop o_mreq. The ack pulses the next cycle.
- Latency: request at cycle N, o_mreq high N+1..M, i_mack at M, ack at M+1. With i_mack at N+1, ack is at N+2.
- Fetch: o_mwe = 0, o_mstrb = 0000, o_maddr = {i_iaddr[31:2], 2'b00}.
- Byte access: o_mstrb = 0001 << a[1:0]; o_mwdata = {4{wd[7:0]}}; read = zero-extended byte at lane a[1:0].
- Half access: o_mstrb = 0011 << {a[1], 0}; o_mwdata = {2{wd[15:0]}}; read = half at lane a[1]; a[0] ignored.
- Word access: o_mstrb = 1111; a[1:0] ignored.
- Loads drive o_mstrb per size and o_mwe = 0. Sign extension stays in the CPU.
- Watchdog: cleared on grant; increments each BUSY cycle with i_mack low.
- Watchdog abort: if the count equals TIMEOUT and i_mack is low, drop o_mreq, go to IDLE, and pulse ack next cycle with data 0. o_derr = 1 for data; fetch abort returns 0 with no error flag.
- i_mack in IDLE: ignored.

Optional Feature:
MEM_ARB_ALIGN_CHECK_EN
- Defined: a data request with half and a[0] = 1, or word and a[1:0] != 00, gets no memory access. o_dack pulses next cycle with o_derr = 1 and o_drdata = 0.
- Undefined: misaligned low address bits are ignored as stated above; o_derr is driven only by timeout.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, IBUSY, DBUSY};
  - memsize constants MS_NONE = 00, MS_BYTE = 01, MS_HALF = 10, MS_WORD = 11, shared with the CPU memsize encoding.
- Sub-module byte_lane (combinational): size + a[1:0] + wdata in; strobes, replicated wdata, extracted read data and misalign flag out.

Test Plan:
- Fetch 0x100, i_mack 3 cycles after o_mreq with i_mrdata = 0x00000013 -> o_maddr 0x100, o_mstrb 0000, o_iack one cycle after i_mack, o_idata 0x13.
- Both req same cycle (store byte 0xAB to 0x203, fetch 0x40) -> data granted first with o_mstrb 1000 and o_mwdata 0xABABABAB; fetch granted after o_dack.
- Load half at 0x12 with i_mrdata 0xBEEF1234 -> o_mstrb 1100, o_drdata 0x0000BEEF.
- TIMEOUT = 4, i_mack never asserted -> o_mreq high exactly 5 cycles, then o_dack with o_derr = 1 and o_drdata = 0.
- i_rst high while DBUSY, i_mack arriving 2 cycles later -> o_mreq 0 after reset edge, no ack, state IDLE.
- With MEM_ARB_ALIGN_CHECK_EN: word load at 0x102 -> o_mreq never rises, o_dack with o_derr = 1 next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and memsize encoding for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    IBUSY = 2'b01,
    DBUSY = 2'b10
  } state_t;

  // Same encoding the CPU uses for its memsize field.
  localparam logic [1:0] MS_NONE = 2'b00;
  localparam logic [1:0] MS_BYTE = 2'b01;
  localparam logic [1:0] MS_HALF = 2'b10;
  localparam logic [1:0] MS_WORD = 2'b11;

endpackage

// File: rtl/mem_arbiter_byte_lane.sv
// Byte-lane steering: strobes, write-data replication and read-data extraction.
// MEM_ARB_ALIGN_CHECK_EN enables the misalignment flag; otherwise it is tied low.
module byte_lane
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        misalign
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    strb      = 4'b0000;
    wdata_rep = '0;
    rdata     = '0;
    case (size)
      MS_BYTE: begin
        strb      = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {24'h0, rword[{addr_lo, 3'b000} +: 8]};
      end
      MS_HALF: begin
        strb      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {16'h0, rword[{addr_lo[1], 4'b0000} +: 16]};
      end
      MS_WORD: begin
        strb      = 4'b1111;
        wdata_rep = wdata;
        rdata     = rword;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign misalign = ((size == MS_HALF) && addr_lo[0]) ||
                    ((size == MS_WORD) && (addr_lo != 2'b00));
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported 32-bit memory between instruction fetch and load/store,
// with a wait-timeout watchdog. MEM_ARB_ALIGN_CHECK_EN rejects misaligned data accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ireq,
  input  logic [31:0] i_iaddr,
  output logic        o_iack,
  output logic [31:0] o_idata,
  input  logic        i_dreq,
  input  logic        i_dwrite,
  input  logic [1:0]  i_dsize,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_dwdata,
  output logic        o_dack,
  output logic [31:0] o_drdata,
  output logic        o_derr,
  output logic        o_mreq,
  output logic        o_mwe,
  output logic [3:0]  o_mstrb,
  output logic [31:0] o_maddr,
  output logic [31:0] o_mwdata,
  input  logic        i_mack,
  input  logic [31:0] i_mrdata
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
  localparam bit               WD_EN    = (TIMEOUT != 0);

  state_t           state;
  logic [1:0]       lat_size;
  logic [1:0]       lat_alo;
  logic [CNT_W-1:0] wd_cnt;

  logic [1:0]  lane_size;
  logic [1:0]  lane_alo;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_misalign;
  logic        unused_iaddr_lo;

  // Fetch addresses are word-aligned by truncation; the low bits carry no meaning.
  assign unused_iaddr_lo = ^i_iaddr[1:0];

  // The lane decoder looks at the live request while idle and the latched one while busy.
  assign lane_size = (state == IDLE) ? i_dsize      : lat_size;
  assign lane_alo  = (state == IDLE) ? i_daddr[1:0] : lat_alo;

  byte_lane u_lane (
    .size      (lane_size),
    .addr_lo   (lane_alo),
    .wdata     (i_dwdata),
    .rword     (i_mrdata),
    .strb      (lane_strb),
    .wdata_rep (lane_wdata),
    .rdata     (lane_rdata),
    .misalign  (lane_misalign)
  );

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state    <= IDLE;
      lat_size <= MS_NONE;
      lat_alo  <= 2'b00;
      wd_cnt   <= '0;
      o_iack   <= 1'b0;
      o_idata  <= '0;
      o_dack   <= 1'b0;
      o_drdata <= '0;
      o_derr   <= 1'b0;
      o_mreq   <= 1'b0;
      o_mwe    <= 1'b0;
      o_mstrb  <= 4'b0000;
      o_maddr  <= '0;
      o_mwdata <= '0;
    end else begin
      o_iack <= 1'b0;
      o_dack <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          // A side's request is ignored while its own ack is still showing.
          if (i_dreq && !o_dack) begin
            if ((i_dsize == MS_NONE) || lane_misalign) begin
              o_dack   <= 1'b1;
              o_drdata <= '0;
              o_derr   <= lane_misalign;
            end else begin
              state    <= DBUSY;
              lat_size <= i_dsize;
              lat_alo  <= i_daddr[1:0];
              o_mreq   <= 1'b1;
              o_mwe    <= i_dwrite;
              o_mstrb  <= lane_strb;
              o_maddr  <= {i_daddr[31:2], 2'b00};
              o_mwdata <= i_dwrite ? lane_wdata : '0;
            end
          end else if (i_ireq && !o_iack) begin
            state    <= IBUSY;
            o_mreq   <= 1'b1;
            o_mwe    <= 1'b0;
            o_mstrb  <= 4'b0000;
            o_maddr  <= {i_iaddr[31:2], 2'b00};
            o_mwdata <= '0;
          end
        end

        IBUSY, DBUSY: begin
          if (i_mack || (WD_EN && (wd_cnt == TO_LIMIT))) begin
            state    <= IDLE;
            o_mreq   <= 1'b0;
            o_mwe    <= 1'b0;
            o_mstrb  <= 4'b0000;
            o_maddr  <= '0;
            o_mwdata <= '0;
            if (state == IBUSY) begin
              o_iack  <= 1'b1;
              o_idata <= i_mack ? i_mrdata : '0;
            end else begin
              o_dack   <= 1'b1;
              o_drdata <= (i_mack && !o_mwe) ? lane_rdata : '0;
              o_derr   <= !i_mack;
            end
          end else if (WD_EN) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_word_aligned: assert property (@(posedge i_clk) disable iff (i_rst)
    o_maddr[1:0] == 2'b00);

  a_single_ack: assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_iack && o_dack));

  a_fetch_reads: assert property (@(posedge i_clk) disable iff (i_rst)
    (state == IBUSY) |-> (!o_mwe && (o_mstrb == 4'b0000)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle-indexed stimulus schedule, a transaction-level
// expectation timeline built from the access rules, and a per-cycle compare process.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TMO  = 4;
  localparam int MAXC = 200;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst, i_ireq, i_dreq, i_dwrite, i_mack;
  logic [31:0] i_iaddr, i_daddr, i_dwdata, i_mrdata;
  logic [1:0]  i_dsize;
  logic        o_iack, o_dack, o_derr, o_mreq, o_mwe;
  logic [31:0] o_idata, o_drdata, o_maddr, o_mwdata;
  logic [3:0]  o_mstrb;

  mem_arbiter #(.TIMEOUT(TMO), .CNT_W(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ireq(i_ireq), .i_iaddr(i_iaddr), .o_iack(o_iack), .o_idata(o_idata),
    .i_dreq(i_dreq), .i_dwrite(i_dwrite), .i_dsize(i_dsize), .i_daddr(i_daddr),
    .i_dwdata(i_dwdata), .o_dack(o_dack), .o_drdata(o_drdata), .o_derr(o_derr),
    .o_mreq(o_mreq), .o_mwe(o_mwe), .o_mstrb(o_mstrb), .o_maddr(o_maddr),
    .o_mwdata(o_mwdata), .i_mack(i_mack), .i_mrdata(i_mrdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit        rst, ireq, dreq, dwrite, mack;
    bit [31:0] iaddr, daddr, dwdata, mrdata;
    bit [1:0]  dsize;
  } stim_t;

  typedef struct {
    bit        mreq, mwe, iack, dack, derr, chk_drdata, zero;
    bit [3:0]  mstrb;
    bit [31:0] maddr, mwdata, idata, drdata;
  } exp_t;

  typedef enum int {L_MREQ, L_MADDR, L_MSTRB, L_MWDATA, L_IACK, L_IDATA,
                    L_DACK, L_DRDATA, L_DERR} lsel_t;
  typedef struct {
    int          cyc;
    lsel_t       sel;
    logic [31:0] val;
    string       name;
  } lit_t;

  stim_t stim[MAXC];
  exp_t  ex[MAXC];
  lit_t  lits[$];
  int    cyc = 0;
  bit    running = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    to_lo = 0, to_hi = -1, to_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, want);
    end
  endtask

  // Reference rules for lane steering, written as plain arithmetic on the byte address.
  function automatic bit [3:0] m_strb(bit [1:0] size, bit [31:0] a);
    case (size)
      2'd1:    return 4'(1 << (a % 4));
      2'd2:    return 4'(3 << (2 * ((a / 2) % 2)));
      2'd3:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic bit [31:0] m_wdata(bit [1:0] size, bit [31:0] wd);
    case (size)
      2'd1:    return (wd & 32'hFF) * 32'h01010101;
      2'd2:    return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic bit [31:0] m_rdata(bit [1:0] size, bit [31:0] a, bit [31:0] rd);
    case (size)
      2'd1:    return (rd >> (8 * (a % 4))) & 32'hFF;
      2'd2:    return (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic bit m_misalign(bit [1:0] size, bit [31:0] a);
    return ALIGN && (((size == 2'd2) && (a % 2 != 0)) || ((size == 2'd3) && (a % 4 != 0)));
  endfunction

  function automatic void add_lit(int c, lsel_t s, logic [31:0] v, string nm);
    lits.push_back('{c, s, v, nm});
  endfunction

  function automatic void set_dreq(int c, bit wr, bit [1:0] size, bit [31:0] a, bit [31:0] wd);
    stim[c].dreq   = 1'b1;
    stim[c].dwrite = wr;
    stim[c].dsize  = size;
    stim[c].daddr  = a;
    stim[c].dwdata = wd;
  endfunction

  // Request raised at cycle n; memory answers delay cycles after o_mreq rises (delay < 0: never).
  // Returns the first cycle after the requester has dropped its request.
  function automatic int sched_data(int n, bit wr, bit [1:0] size, bit [31:0] a,
                                    bit [31:0] wd, bit [31:0] rd, int delay);
    int last, ackc;
    bit abort;
    if ((size == 2'd0) || m_misalign(size, a)) begin
      ackc = n + 1;
      ex[ackc].derr       = m_misalign(size, a);
      ex[ackc].drdata     = 32'h0;
      ex[ackc].chk_drdata = 1'b1;
    end else begin
      abort = (delay < 0) || (delay > TMO);
      last  = abort ? n + 1 + TMO : n + 1 + delay;
      for (int c = n + 1; c <= last; c++) begin
        ex[c].mreq   = 1'b1;
        ex[c].maddr  = a - (a % 4);
        ex[c].mwe    = wr;
        ex[c].mstrb  = m_strb(size, a);
        ex[c].mwdata = m_wdata(size, wd);
      end
      if (!abort) begin
        stim[last].mack   = 1'b1;
        stim[last].mrdata = rd;
      end
      ackc = last + 1;
      ex[ackc].derr       = abort;
      ex[ackc].drdata     = (abort || wr) ? 32'h0 : m_rdata(size, a, rd);
      ex[ackc].chk_drdata = !wr || abort;
    end
    ex[ackc].dack = 1'b1;
    for (int c = n; c <= ackc; c++) set_dreq(c, wr, size, a, wd);
    return ackc + 1;
  endfunction

  function automatic int sched_fetch(int n, bit [31:0] a, bit [31:0] rd, int delay);
    int last, ackc;
    bit abort;
    abort = (delay < 0) || (delay > TMO);
    last  = abort ? n + 1 + TMO : n + 1 + delay;
    for (int c = n + 1; c <= last; c++) begin
      ex[c].mreq  = 1'b1;
      ex[c].maddr = a - (a % 4);
    end
    if (!abort) begin
      stim[last].mack   = 1'b1;
      stim[last].mrdata = rd;
    end
    ackc = last + 1;
    ex[ackc].iack  = 1'b1;
    ex[ackc].idata = abort ? 32'h0 : rd;
    for (int c = n; c <= ackc; c++) begin
      stim[c].ireq  = 1'b1;
      stim[c].iaddr = a;
    end
    return ackc + 1;
  endfunction

  function automatic logic [31:0] pick(lsel_t s);
    case (s)
      L_MREQ:   return 32'(o_mreq);
      L_MADDR:  return o_maddr;
      L_MSTRB:  return 32'(o_mstrb);
      L_MWDATA: return o_mwdata;
      L_IACK:   return 32'(o_iack);
      L_IDATA:  return o_idata;
      L_DACK:   return 32'(o_dack);
      L_DRDATA: return o_drdata;
      default:  return 32'(o_derr);
    endcase
  endfunction

  task automatic apply(input int c);
    i_rst    = stim[c].rst;
    i_ireq   = stim[c].ireq;
    i_iaddr  = stim[c].iaddr;
    i_dreq   = stim[c].dreq;
    i_dwrite = stim[c].dwrite;
    i_dsize  = stim[c].dsize;
    i_daddr  = stim[c].daddr;
    i_dwdata = stim[c].dwdata;
    i_mack   = stim[c].mack;
    i_mrdata = stim[c].mrdata;
  endtask

  always @(negedge i_clk) begin
    if (running && cyc >= 1) begin
      check("mreq", 32'(o_mreq), 32'(ex[cyc].mreq));
      check("iack", 32'(o_iack), 32'(ex[cyc].iack));
      check("dack", 32'(o_dack), 32'(ex[cyc].dack));
      if (ex[cyc].mreq) begin
        check("maddr", o_maddr, ex[cyc].maddr);
        check("mwe", 32'(o_mwe), 32'(ex[cyc].mwe));
        check("mstrb", 32'(o_mstrb), 32'(ex[cyc].mstrb));
        if (ex[cyc].mwe) check("mwdata", o_mwdata, ex[cyc].mwdata);
      end
      if (ex[cyc].iack) check("idata", o_idata, ex[cyc].idata);
      if (ex[cyc].dack) begin
        check("derr", 32'(o_derr), 32'(ex[cyc].derr));
        if (ex[cyc].chk_drdata) check("drdata", o_drdata, ex[cyc].drdata);
      end
      if (ex[cyc].zero)
        check("reset_outputs_zero",
              32'(|{o_iack, o_idata, o_dack, o_drdata, o_derr,
                    o_mreq, o_mwe, o_mstrb, o_maddr, o_mwdata}), 32'h0);
      foreach (lits[i])
        if (lits[i].cyc == cyc) check(lits[i].name, pick(lits[i].sel), lits[i].val);
      if ((cyc >= to_lo) && (cyc <= to_hi) && (o_mreq === 1'b1)) to_cnt++;
    end
  end

  initial begin
    int n, nx, a, run_len;
    for (int c = 0; c < MAXC; c++) begin
      stim[c] = '{default: 0};
      ex[c]   = '{default: 0};
    end
    stim[0].rst = 1'b1;
    stim[1].rst = 1'b1;
    ex[1].zero  = 1'b1;
    ex[2].zero  = 1'b1;
    n = 3;

    // Fetch 0x100, memory answers 3 cycles after o_mreq rises.
    nx = sched_fetch(n, 32'h100, 32'h13, 3);
    add_lit(n + 1, L_MADDR, 32'h100, "fetch_maddr");
    add_lit(n + 1, L_MSTRB, 32'h0, "fetch_mstrb");
    add_lit(n + 5, L_IACK, 32'h1, "fetch_iack_time");
    add_lit(n + 5, L_IDATA, 32'h13, "fetch_idata");
    n = nx;

    // Simultaneous requests: byte store wins, fetch is granted in the dack cycle.
    nx = sched_data(n, 1'b1, MS_BYTE, 32'h203, 32'hAB, 32'h0, 1);
    for (int c = n; c <= nx - 2; c++) begin
      stim[c].ireq  = 1'b1;
      stim[c].iaddr = 32'h40;
    end
    nx = sched_fetch(nx - 1, 32'h40, 32'h00112233, 0);
    add_lit(n + 1, L_MSTRB, 32'h8, "both_store_mstrb");
    add_lit(n + 1, L_MWDATA, 32'hABABABAB, "both_store_mwdata");
    add_lit(n + 1, L_MADDR, 32'h200, "both_store_maddr");
    add_lit(n + 3, L_DACK, 32'h1, "both_dack_time");
    add_lit(n + 4, L_MADDR, 32'h40, "both_fetch_maddr");
    n = nx;

    // Half load at 0x12, memory answers immediately.
    nx = sched_data(n, 1'b0, MS_HALF, 32'h12, 32'h0, 32'hBEEF1234, 0);
    add_lit(n + 1, L_MSTRB, 32'hC, "half_load_mstrb");
    add_lit(n + 2, L_DRDATA, 32'h0000BEEF, "half_load_drdata");
    n = nx;

    // Memory never answers: watchdog abort after TMO+1 request cycles.
    to_lo = n + 1;
    to_hi = n + 6;
    nx = sched_data(n, 1'b0, MS_WORD, 32'h300, 32'h0, 32'h0, -1);
    add_lit(n + 6, L_DACK, 32'h1, "timeout_dack");
    add_lit(n + 6, L_DERR, 32'h1, "timeout_derr");
    add_lit(n + 6, L_DRDATA, 32'h0, "timeout_drdata");
    n = nx;

    // Stray i_mack while idle must be ignored.
    stim[n + 1].mack   = 1'b1;
    stim[n + 1].mrdata = 32'hFFFFFFFF;
    n = n + 3;

    // Size none: no memory access, ack next cycle.
    nx = sched_data(n, 1'b1, MS_NONE, 32'h55, 32'h12345678, 32'h0, 0);
    add_lit(n + 1, L_DACK, 32'h1, "none_dack");
    add_lit(n + 1, L_MREQ, 32'h0, "none_no_mreq");
    n = nx;

    nx = sched_data(n, 1'b0, MS_BYTE, 32'h1001, 32'h0, 32'h11AA22BB, 2);
    add_lit(n + 4, L_DRDATA, 32'h22, "byte_load_lane1");
    n = nx;

    nx = sched_data(n, 1'b1, MS_HALF, 32'h6, 32'h1234CAFE, 32'h0, 1);
    add_lit(n + 1, L_MSTRB, 32'hC, "half_store_mstrb");
    add_lit(n + 1, L_MWDATA, 32'hCAFECAFE, "half_store_mwdata");
    n = nx;

    // Answer lands on the last cycle before abort: normal completion.
    nx = sched_data(n, 1'b1, MS_WORD, 32'h44, 32'hDEADBEEF, 32'h0, TMO);
    add_lit(n + 1, L_MWDATA, 32'hDEADBEEF, "word_store_mwdata");
    add_lit(n + TMO + 2, L_DACK, 32'h1, "edge_timeout_dack");
    add_lit(n + TMO + 2, L_DERR, 32'h0, "edge_timeout_no_err");
    n = nx;

    nx = sched_fetch(n, 32'h80, 32'h0, -1);
    add_lit(n + TMO + 2, L_IACK, 32'h1, "fetch_timeout_iack");
    add_lit(n + TMO + 2, L_IDATA, 32'h0, "fetch_timeout_idata");
    n = nx;

    nx = sched_data(n, 1'b0, MS_WORD, 32'h102, 32'h0, 32'h87654321, 0);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    add_lit(n + 1, L_MREQ, 32'h0, "misalign_no_mreq");
    add_lit(n + 1, L_DACK, 32'h1, "misalign_dack");
    add_lit(n + 1, L_DERR, 32'h1, "misalign_derr");
`else
    add_lit(n + 1, L_MADDR, 32'h100, "unaligned_word_maddr");
    add_lit(n + 1, L_MSTRB, 32'hF, "unaligned_word_mstrb");
    add_lit(n + 2, L_DRDATA, 32'h87654321, "unaligned_word_drdata");
`endif
    n = nx;

    // Data request arrives during a fetch and is granted in the iack cycle.
    nx = sched_fetch(n, 32'h200, 32'hA5A5A5A5, 2);
    a  = nx - 1;
    for (int c = n + 1; c < a; c++) set_dreq(c, 1'b1, MS_BYTE, 32'hA1, 32'h55);
    nx = sched_data(a, 1'b1, MS_BYTE, 32'hA1, 32'h55, 32'h0, 0);
    add_lit(a + 1, L_MSTRB, 32'h2, "wait_store_mstrb");
    add_lit(a + 1, L_MWDATA, 32'h55555555, "wait_store_mwdata");
    n = nx;

    // Reset while DBUSY; a late i_mack is ignored.
    for (int c = n; c <= n + 2; c++) set_dreq(c, 1'b0, MS_WORD, 32'h400, 32'h0);
    for (int c = n + 1; c <= n + 2; c++) begin
      ex[c].mreq  = 1'b1;
      ex[c].maddr = 32'h400;
      ex[c].mstrb = 4'hF;
    end
    stim[n + 2].rst    = 1'b1;
    ex[n + 3].zero     = 1'b1;
    stim[n + 4].mack   = 1'b1;
    stim[n + 4].mrdata = 32'h99;
    add_lit(n + 3, L_MREQ, 32'h0, "reset_drops_mreq");
    n = n + 8;

    nx = sched_fetch(n, 32'h1C, 32'h77, 0);
    add_lit(n + 2, L_IDATA, 32'h77, "post_reset_fetch");
    run_len = nx + 3;

    apply(0);
    running = 1'b1;
    for (int c = 1; c < run_len; c++) begin
      @(posedge i_clk);
      #1;
      cyc = c;
      apply(c);
    end
    @(negedge i_clk);
    #1;
    running = 1'b0;
    check("timeout_mreq_cycles", 32'(to_cnt), 32'd5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
